// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared constants, the fill-progress state type and a
// saturating-increment helper for the serial pattern detector.
package seq_detect_pkg;

    localparam int unsigned SEQ_PAT_W_DEFAULT = 5;
    localparam int unsigned SEQ_CNT_W_DEFAULT = 8;
    localparam logic [SEQ_PAT_W_DEFAULT-1:0] SEQ_PAT_DEFAULT = 5'b10101;

    // Progress of the sample window: FILLING until PAT_W bits have been
    // taken since reset/restart, ARMED afterwards.
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } fill_state_e;

    // Returns val+1, or max once val has reached max.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_shift_window.sv
// seq_shift_window: PAT_W-bit serial sample window with a saturating fill
// counter that tracks how many bits have been taken since reset/restart.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset (window and fill to zero)
//   en      sample enable; in is shifted in only when en=1
//   clr     synchronous clear of window and fill (wins over en)
//   in      serial data bit
//   window  current window contents, newest bit in bit 0
//   full    high when the next enabled bit completes a full window
//           (fill >= PAT_W-1)
module seq_shift_window
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_W = SEQ_PAT_W_DEFAULT
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             in,
    output logic [PAT_W-1:0] window,
    output logic             full
);

    localparam int unsigned        FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  r_window;
    logic [FILL_W-1:0] r_fill;
    fill_state_e       w_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_window <= '0;
            r_fill   <= '0;
        end else if (clr) begin
            r_window <= '0;
            r_fill   <= '0;
        end else if (en) begin
            r_window <= {r_window[PAT_W-2:0], in};
            if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    always_comb begin
        w_state = (r_fill == FILL_MAX) ? ARMED : FILLING;
    end

    assign window = r_window;
    assign full   = (w_state == ARMED) || (r_fill == FILL_LAST);

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial bit-pattern detector with sample
// enable, one-cycle registered match pulse and a saturating match counter.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   en         sample enable; in is consumed only on edges with en=1
//   in         serial data bit (MSB of PATTERN arrives first)
//   clr_cnt    synchronous clear of match_cnt (a coincident match gives 1)
//   out        registered match pulse, one cycle per match
//   match_cnt  saturating match count since reset/clear
//   pat_load   (SEQ_DETECT_PROG_EN only) load pat_val as the pattern and
//              restart the window on the same edge
//   pat_val    (SEQ_DETECT_PROG_EN only) new pattern value
//
// Build option: define SEQ_DETECT_PROG_EN for a runtime-loadable pattern;
// otherwise the pattern is the constant PATTERN.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned      PAT_W   = SEQ_PAT_W_DEFAULT,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_PAT_DEFAULT),
    parameter int unsigned      OVERLAP = 1,
    parameter int unsigned      CNT_W   = SEQ_CNT_W_DEFAULT
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
`ifdef SEQ_DETECT_PROG_EN
    ,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_val
`endif
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [PAT_W-1:0] w_window;
    logic [PAT_W-1:0] w_nxt_window;
    logic [PAT_W-1:0] w_pat;
    logic             w_full;
    logic             w_load;
    logic             w_match;
    logic             w_clr_win;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;

`ifdef SEQ_DETECT_PROG_EN
    logic [PAT_W-1:0] r_pat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat <= PATTERN;
        end else if (pat_load) begin
            r_pat <= pat_val;
        end
    end

    assign w_pat  = r_pat;
    assign w_load = pat_load;
`else
    assign w_pat  = PATTERN;
    assign w_load = 1'b0;
`endif

    // Non-overlap restart clears the whole window rather than only fill:
    // the next match needs PAT_W fresh bits anyway, so the stale window
    // contents can never be compared and the result is identical.
    assign w_clr_win = w_load || ((OVERLAP == 0) && w_match);

    seq_shift_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .clr    (w_clr_win),
        .in     (in),
        .window (w_window),
        .full   (w_full)
    );

    // Compare against the window as it will be after this edge's shift.
    assign w_nxt_window = {w_window[PAT_W-2:0], in};
    assign w_match      = en && w_full && (w_nxt_window == w_pat) && !w_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_out <= w_match;
            if (clr_cnt) begin
                r_cnt <= w_match ? CNT_W'(1) : '0;
            end else if (w_match) begin
                r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_MAX));
            end
        end
    end

    assign out       = r_out;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;
    import seq_detect_pkg::*;

    localparam int PW = 5;

    logic       clk = 1'b0;
    logic       reset, en, in, clr_cnt;
    logic       out_d, out_n, out_s;
    logic [7:0] cnt_d, cnt_n;
    logic [1:0] cnt_s;
`ifdef SEQ_DETECT_PROG_EN
    logic          pat_load;
    logic [PW-1:0] pat_val;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_detect_param dut_d (
        .clk(clk), .reset(reset), .en(en), .in(in), .clr_cnt(clr_cnt),
        .out(out_d), .match_cnt(cnt_d)
`ifdef SEQ_DETECT_PROG_EN
        , .pat_load(pat_load), .pat_val(pat_val)
`endif
    );

    seq_detect_param #(.OVERLAP(0)) dut_n (
        .clk(clk), .reset(reset), .en(en), .in(in), .clr_cnt(clr_cnt),
        .out(out_n), .match_cnt(cnt_n)
`ifdef SEQ_DETECT_PROG_EN
        , .pat_load(pat_load), .pat_val(pat_val)
`endif
    );

    seq_detect_param #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .en(en), .in(in), .clr_cnt(clr_cnt),
        .out(out_s), .match_cnt(cnt_s)
`ifdef SEQ_DETECT_PROG_EN
        , .pat_load(pat_load), .pat_val(pat_val)
`endif
    );

    // Reference model: per instance, the bits sampled since the last
    // reset/restart (at most PW kept). A match is "the last PW sampled bits
    // spell the pattern". Index 0 = defaults, 1 = OVERLAP=0, 2 = CNT_W=2.
    bit            hist[3][$];
    int            m_cnt[3];
    bit            m_out[3];
    int            m_max[3] = '{255, 255, 3};
    bit            m_ovl[3] = '{1'b1, 1'b0, 1'b1};
    logic [PW-1:0] m_pat;

    function automatic bit window_matches(int k);
        if (hist[k].size() != PW) return 1'b0;
        for (int i = 0; i < PW; i++) begin
            if (hist[k][i] != m_pat[PW-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            hist[k].delete();
            m_cnt[k] = 0;
            m_out[k] = 1'b0;
        end
        m_pat = SEQ_PAT_DEFAULT;
    endtask

    task automatic model_step(input bit e, input bit b, input bit c,
                              input bit ld, input logic [PW-1:0] v);
        for (int k = 0; k < 3; k++) begin
            bit hit;
            hit = 1'b0;
            if (ld) begin
                hist[k].delete();
            end else if (e) begin
                hist[k].push_back(b);
                if (hist[k].size() > PW) void'(hist[k].pop_front());
                hit = window_matches(k);
                if (hit && !m_ovl[k]) hist[k].delete();
            end
            m_out[k] = hit;
            if (c) m_cnt[k] = hit ? 1 : 0;
            else if (hit && m_cnt[k] < m_max[k]) m_cnt[k]++;
        end
        if (ld) m_pat = v;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    endtask

    task automatic check_all();
        check("out_def",   int'(out_d), int'(m_out[0]));
        check("cnt_def",   int'(cnt_d), m_cnt[0]);
        check("out_novl",  int'(out_n), int'(m_out[1]));
        check("cnt_novl",  int'(cnt_n), m_cnt[1]);
        check("out_cnt2",  int'(out_s), int'(m_out[2]));
        check("cnt_cnt2",  int'(cnt_s), m_cnt[2]);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input bit e, input bit b, input bit c = 1'b0,
                         input bit ld = 1'b0, input logic [PW-1:0] v = '0);
        en = e; in = b; clr_cnt = c;
`ifdef SEQ_DETECT_PROG_EN
        pat_load = ld; pat_val = v;
`endif
        @(posedge clk);
        model_step(e, b, c, ld, v);
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Asynchronous one-cycle reset pulse, starting and ending at a negedge.
    task automatic pulse_reset();
        en = 1'b0; in = 1'b0; clr_cnt = 1'b0;
`ifdef SEQ_DETECT_PROG_EN
        pat_load = 1'b0;
`endif
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit en;
        bit in;
        bit clr;
        bit eo_d;
        int ec_d;
        bit eo_n;
        int ec_n;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [PW-1:0] bits5;

        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 1, 1, 1, 1};
        tbl[5]  = '{1, 0, 0, 0, 1, 0, 1};
        tbl[6]  = '{1, 1, 0, 1, 2, 0, 1};
        tbl[7]  = '{1, 1, 0, 0, 2, 0, 1};
        tbl[8]  = '{1, 0, 0, 0, 2, 0, 1};
        tbl[9]  = '{1, 1, 0, 0, 2, 0, 1};
        tbl[10] = '{1, 0, 0, 0, 2, 0, 1};
        tbl[11] = '{1, 1, 0, 1, 3, 1, 2};

        reset = 1'b1; en = 1'b0; in = 1'b0; clr_cnt = 1'b0;
`ifdef SEQ_DETECT_PROG_EN
        pat_load = 1'b0; pat_val = '0;
`endif
        model_reset();
        @(posedge clk); #1;
        check("reset_out", int'(out_d), 0);
        check("reset_cnt", int'(cnt_d), 0);
        check_all();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Tests 1/2: overlapping vs restarting detection on one stream.
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].en, tbl[i].in, tbl[i].clr);
            check($sformatf("tbl%0d_out_def", i),  int'(out_d), int'(tbl[i].eo_d));
            check($sformatf("tbl%0d_cnt_def", i),  int'(cnt_d), tbl[i].ec_d);
            check($sformatf("tbl%0d_out_novl", i), int'(out_n), int'(tbl[i].eo_n));
            check($sformatf("tbl%0d_cnt_novl", i), int'(cnt_n), tbl[i].ec_n);
        end

        // Test 3: reset mid-pattern discards the partial window.
        pulse_reset();
        cycle(1, 1); cycle(1, 0); cycle(1, 1); cycle(1, 0);
        pulse_reset();
        cycle(1, 1);
        check("t3_no_pulse", int'(out_d), 0);
        bits5 = 5'b10101;
        for (int i = PW - 1; i >= 0; i--) cycle(1, bits5[i]);
        check("t3_pulse", int'(out_d), 1);
        check("t3_cnt", int'(cnt_d), 1);

        // Test 4: enable gaps between bits.
        pulse_reset();
        for (int i = PW - 1; i >= 0; i--) begin
            cycle(1, bits5[i]);
            if (i != 0) begin
                for (int g = 0; g < 3; g++) begin
                    cycle(0, 1'($urandom_range(0, 1)));
                    check("t4_gap_out", int'(out_d), 0);
                end
            end
        end
        check("t4_pulse", int'(out_d), 1);
        cycle(0, 1);
        check("t4_after", int'(out_d), 0);
        check("t4_cnt", int'(cnt_d), 1);

        // Test 5: saturation, clear on a match edge, clear while disabled.
        pulse_reset();
        for (int i = 0; i < 20; i++) cycle(1, (i % 2) == 0);
        check("t5_sat_cnt2", int'(cnt_s), 3);
        check("t5_cnt_def", int'(cnt_d), 8);
        check("t5_cnt_novl", int'(cnt_n), 3);
        cycle(1, 1, 1);
        check("t5_clr_match_cnt2", int'(cnt_s), 1);
        check("t5_clr_match_def", int'(cnt_d), 1);
        check("t5_clr_match_out", int'(out_d), 1);
        cycle(0, 0, 1);
        check("t5_clr_idle", int'(cnt_d), 0);
        cycle(1, 0);
        cycle(1, 1);
        check("t5_hold_out", int'(out_d), 1);
        check("t5_hold_cnt", int'(cnt_d), 1);

`ifdef SEQ_DETECT_PROG_EN
        // Test 6: runtime pattern load.
        pulse_reset();
        cycle(1, 1); cycle(1, 0); cycle(1, 1); cycle(1, 0);
        cycle(1, 1, 0, 1, 5'b11100);
        check("t6_load_no_match", int'(out_d), 0);
        bits5 = 5'b11100;
        for (int i = PW - 1; i >= 0; i--) cycle(1, bits5[i]);
        check("t6_new_pulse", int'(out_d), 1);
        bits5 = 5'b10101;
        for (int i = PW - 1; i >= 0; i--) begin
            cycle(1, bits5[i]);
            check("t6_old_none", int'(out_d), 0);
        end
        check("t6_cnt", int'(cnt_d), 1);
`endif

        // Randomised run against the model.
        pulse_reset();
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                pulse_reset();
            end
`ifdef SEQ_DETECT_PROG_EN
            else if (r < 3) begin
                logic [PW-1:0] pv;
                case ($urandom_range(0, 3))
                    0: pv = 5'b10101;
                    1: pv = 5'b11100;
                    2: pv = 5'b00000;
                    default: pv = PW'($urandom);
                endcase
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'b0, 1'b1, pv);
            end
`endif
            else begin
                cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 19) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector. It is the generalised successor of the fixed 5-bit "10101" detector.
- Pattern, pattern width and overlap mode are set by parameter.
- Adds a sample-enable and a saturating match counter with synchronous clear.
- Sits on a 1-bit serial input stream. Emits a one-cycle registered match pulse.

Parameters:
PAT_W, 5, pattern length in bits (2..32)
PATTERN, 5'b10101, pattern to detect (PAT_W bits); MSB is the earliest-arriving bit
OVERLAP, 1, 1 = overlapping matches allowed; 0 = window restarts after each match
CNT_W, 8, width of match counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  sample enable; in is consumed only on edges where en=1
in  input  1  serial data bit
clr_cnt  input  1  synchronous clear of match_cnt
out  output  1  registered match pulse, high for exactly one cycle per match
match_cnt  output  CNT_W  saturating count of matches since reset/clear

Behaviour:
- Reset (async, active-high) forces the following; it takes effect immediately, including mid-pattern:
  - window = 0, fill = 0, out = 0, match_cnt = 0
- Window: PAT_W-bit shift register. On a posedge with en=1, window <= {window[PAT_W-2:0], in}. With en=0 the window holds.
- Fill counter: 0..PAT_W, saturates at PAT_W. It increments on each en=1 edge and prevents false matches on the reset-zero window.
- Match condition, evaluated on an en=1 edge using the updated window: nxt_window == PATTERN and fill+1 >= PAT_W.
- out is registered. It is high during the cycle after the edge that sampled the completing bit, and low otherwise (including en=0 cycles).
- Overlap mode:
  - OVERLAP=1: window and fill are kept after a match, so the "10101" stream 1,0,1,0,1,0,1 yields two matches.
  - OVERLAP=0: fill is set to 0 on the match edge, so the next match needs PAT_W fresh bits. The same stream yields one match.
- Latency: 1 clock from the sampling edge of the last pattern bit to out=1.
- match_cnt:
  - Increments by 1 on each match edge and saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 sets it to 0.
  - If clr_cnt and a match occur on the same edge, match_cnt becomes 1 (the match is not lost).
- en=0 and clr_cnt=1 together: the count clears and the window holds.
- State view: fill acts as the FSM progress state (FILLING while fill<PAT_W, ARMED when fill==PAT_W).

Optional Feature:
Macro SEQ_DETECT_PROG_EN.
- Defined:
  - Adds ports pat_load (input, 1) and pat_val (input, PAT_W).
  - An internal pattern register is reset to PATTERN. On an edge with pat_load=1 it loads pat_val, and window and fill are cleared on the same edge.
  - No match can be reported on a load edge.
- Undefined: the ports are absent and the pattern is the constant PATTERN.

Decomposition:
- Package seq_detect_pkg holds:
  - the default pattern constant (SEQ_PAT_DEFAULT = 5'b10101) and default widths
  - a saturating-increment function
- One sub-module, seq_shift_window: the shift register plus fill counter, with ports clk, reset, en, clr, in, window, full.
- The top level holds the compare, the out register and match_cnt.

Test Plan:
1. Defaults, reset held 20 ns, then in = 1,0,1,0,1,0,1 with en=1 each cycle -> out pulses one cycle after the 5th and 7th bits; match_cnt=2.
2. OVERLAP=0, same stream -> a single out pulse after the 5th bit; match_cnt=1. A second 1,0,1,0,1 after that -> match_cnt=2.
3. Bits 1,0,1,0 sampled; reset pulsed for one cycle; then 1 -> no pulse. A full 1,0,1,0,1 afterwards -> one pulse.
4. Stream 1,0,1,0,1 with en=0 inserted for 3 cycles between bits -> exactly one pulse, one cycle after the last enabled edge; out=0 during en=0 gaps.
5. CNT_W=2, stream of 1,0 repeated for 20 bits (overlapping) -> match_cnt saturates at 3. clr_cnt asserted on a match edge -> match_cnt=1.
6. With SEQ_DETECT_PROG_EN: load pat_val=5'b11100, then send 1,1,1,0,0 -> one pulse. A subsequent 1,0,1,0,1 -> no pulse.
